alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_ctrl_if.sv | 28 ++
 rtl/alu_ref_model.sv | 33 +++
 rtl/alu_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, result-flag bit
// positions and the sequencer FSM state type.
package alu_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 5;
  localparam int unsigned FLG_W  = 3;
  localparam int unsigned SET_W  = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  // Bit positions inside the {AGB,AEB,ALB} flag vector
  localparam int unsigned FLG_AGB = 2;
  localparam int unsigned FLG_AEB = 1;
  localparam int unsigned FLG_ALB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle of the ALU sequencer.
//   req_valid/req_ready, req_op, req_a, req_b : operation request
//   rsp_valid/rsp_ready, rsp_y, rsp_flags     : captured result
// master = requester/consumer, slave = sequencer.
interface alu_seq_ctrl_if;
  import alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [OPND_W-1:0]    req_a;
  logic [OPND_W-1:0]    req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RES_W-1:0]     rsp_y;
  logic [FLG_W-1:0]     rsp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_flags
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational expected-result model of the external ALU.
//   op, a, b : operation and unsigned operands
//   y, flags : expected result and {AGB,AEB,ALB}
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [RES_W-1:0]  y,
  output logic [FLG_W-1:0]  flags
);

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      OP_ADD:  y = RES_W'({1'b0, a}) + RES_W'({1'b0, b});
      OP_SUB:  y = RES_W'({1'b0, a}) - RES_W'({1'b0, b});
      OP_CMP:  y = '0;
      OP_AND:  y = RES_W'({1'b0, a & b});
      default: y = '0;
    endcase
  end

  // Flags are the unsigned comparison regardless of op
  always_comb begin
    flags          = '0;
    flags[FLG_AGB] = (a > b);
    flags[FLG_AEB] = (a == b);
    flags[FLG_ALB] = (a < b);
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: accepts one operation, drives it to an external
// combinational ALU for SETTLE_CYCLES cycles, captures the result and
// holds it until the consumer takes it.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request/response handshake bundle
//   alu_S/A/B/enable  : registered drive to the ALU
//   alu_Y, alu_AGB/AEB/ALB : ALU result inputs
//   ops_done          : completed-operation count (wraps)
//   err_sticky, err_count : only with ALU_SEQ_SCOREBOARD_EN defined;
//                       result mismatch against the built-in reference
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_ctrl_if.slave     bus,
  output logic [1:0]        alu_S,
  output logic              alu_enable,
  output logic [OPND_W-1:0] alu_A,
  output logic [OPND_W-1:0] alu_B,
  input  logic [RES_W-1:0]  alu_Y,
  input  logic              alu_AGB,
  input  logic              alu_AEB,
  input  logic              alu_ALB,
  output logic [CNT_W-1:0]  ops_done
`ifdef ALU_SEQ_SCOREBOARD_EN
  ,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
`endif
);

  seq_state_e       state;
  logic [SET_W-1:0] settle_cnt;
  logic             capture_c;
  logic [FLG_W-1:0] flags_in_c;

  assign capture_c  = (state == ISSUE) && (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign flags_in_c = {alu_AGB, alu_AEB, alu_ALB};

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_flags <= '0;
      alu_S         <= '0;
      alu_A         <= '0;
      alu_B         <= '0;
      alu_enable    <= 1'b0;
      ops_done      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            alu_S         <= bus.req_op;
            alu_A         <= bus.req_a;
            alu_B         <= bus.req_b;
            alu_enable    <= 1'b1;
            bus.req_ready <= 1'b0;
            settle_cnt    <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (capture_c) begin
            bus.rsp_y     <= alu_Y;
            bus.rsp_flags <= flags_in_c;
            bus.rsp_valid <= 1'b1;
            alu_enable    <= 1'b0;
            settle_cnt    <= '0;
            state         <= RESP;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        RESP: begin
          // req_ready returns only on the next cycle: no bypass
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            ops_done      <= ops_done + CNT_W'(1);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_SCOREBOARD_EN
  logic [RES_W-1:0] exp_y_c;
  logic [FLG_W-1:0] exp_flags_c;

  alu_ref_model u_ref (
    .op    (alu_S),
    .a     (alu_A),
    .b     (alu_B),
    .y     (exp_y_c),
    .flags (exp_flags_c)
  );

  // Mismatch is registered on the capture edge, visible with rsp_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (capture_c && ({alu_Y, flags_in_c} != {exp_y_c, exp_flags_c})) begin
      err_sticky <= 1'b1;
      if (err_count != {CNT_W{1'b1}}) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural ALU
// (optionally faulted for the scoreboard scenario).
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alu_S;
  logic       alu_enable;
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic [4:0] alu_Y;
  logic       alu_AGB;
  logic       alu_AEB;
  logic       alu_ALB;
  logic [7:0] ops_done;
  logic       inject_fault;
`ifdef ALU_SEQ_SCOREBOARD_EN
  logic       err_sticky;
  logic [7:0] err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ops = 0;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_S      (alu_S),
    .alu_enable (alu_enable),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Y      (alu_Y),
    .alu_AGB    (alu_AGB),
    .alu_AEB    (alu_AEB),
    .alu_ALB    (alu_ALB),
    .ops_done   (ops_done)
`ifdef ALU_SEQ_SCOREBOARD_EN
    ,
    .err_sticky (err_sticky),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  // External ALU; the fault stub returns 0 for add
  always_comb begin
    alu_Y = 5'd0;
    case (alu_S)
      2'b00:   alu_Y = {1'b0, alu_A} + {1'b0, alu_B};
      2'b01:   alu_Y = {1'b0, alu_A} - {1'b0, alu_B};
      2'b10:   alu_Y = 5'd0;
      default: alu_Y = {1'b0, alu_A & alu_B};
    endcase
    if (inject_fault && alu_S == 2'b00) alu_Y = 5'd0;
    alu_AGB = alu_A > alu_B;
    alu_AEB = alu_A == alu_B;
    alu_ALB = alu_A < alu_B;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ops = 0;
  endtask

  // Full operation with rsp_ready high: accept in N, result in N+2
  task automatic do_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [4:0] ey, input logic [2:0] ef);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    check({tag, "_rdy_n"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_en_n1"}, 32'(alu_enable), 32'd1);
    check({tag, "_rv_n1"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rdy_n1"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_drive"}, {26'd0, alu_S, alu_A, alu_B} & 32'h3ff, {22'd0, op, a, b});
    tick();
    check({tag, "_rv_n2"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_y"}, 32'(bus.rsp_y), 32'(ey));
    check({tag, "_flags"}, 32'(bus.rsp_flags), 32'(ef));
    check({tag, "_en_n2"}, 32'(alu_enable), 32'd0);
    tick();
    exp_ops = (exp_ops + 1) % 256;
    check({tag, "_rv_n3"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ops"}, 32'(ops_done), 32'(exp_ops));
    check({tag, "_rdy_n3"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    inject_fault  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 4'd0;
    bus.req_b     = 4'd0;
    bus.rsp_ready = 1'b0;

    do_reset();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_en", 32'(alu_enable), 32'd0);
    check("rst_ops", 32'(ops_done), 32'd0);
    check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("rst_alu_in", {26'd0, alu_S, alu_A, alu_B}, 32'd0);

    do_op("add", 2'b00, 4'd12, 4'd3, 5'b01111, 3'b100);
    do_op("sub", 2'b01, 4'd3, 4'd12, 5'b10111, 3'b001);
    do_op("cmp", 2'b10, 4'd5, 4'd5, 5'b00000, 3'b010);
    do_op("and", 2'b11, 4'd12, 4'd3, 5'b00000, 3'b100);
    do_op("add_max", 2'b00, 4'd15, 4'd15, 5'b11110, 3'b010);
    check("hold_alu_A", 32'(alu_A), 32'd15);

    // Backpressure with a second request waiting
    bus.req_op    = 2'b00;
    bus.req_a     = 4'd1;
    bus.req_b     = 4'd2;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_op = 2'b11;
    bus.req_a  = 4'd15;
    bus.req_b  = 4'd6;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_y", 32'(bus.rsp_y), 32'd3);
      check("bp_flags", 32'(bus.rsp_flags), 32'b001);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_alu_A", 32'(alu_A), 32'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    exp_ops++;
    check("bp_rel_rv", 32'(bus.rsp_valid), 32'd0);
    check("bp_rel_rdy", 32'(bus.req_ready), 32'd1);
    check("bp_rel_en", 32'(alu_enable), 32'd0);
    check("bp_rel_ops", 32'(ops_done), 32'(exp_ops));
    tick();
    bus.req_valid = 1'b0;
    check("bp2_en", 32'(alu_enable), 32'd1);
    check("bp2_A", 32'(alu_A), 32'd15);
    tick();
    check("bp2_rv", 32'(bus.rsp_valid), 32'd1);
    check("bp2_y", 32'(bus.rsp_y), 32'd6);
    tick();
    exp_ops++;
    check("bp2_ops", 32'(ops_done), 32'(exp_ops));

    // Reset while in ISSUE aborts the operation
    do_reset();
    bus.req_op    = 2'b00;
    bus.req_a     = 4'd7;
    bus.req_b     = 4'd1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("mid_issue_en", 32'(alu_enable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rv", 32'(bus.rsp_valid), 32'd0);
    check("mid_rdy", 32'(bus.req_ready), 32'd1);
    check("mid_en", 32'(alu_enable), 32'd0);
    check("mid_ops", 32'(ops_done), 32'd0);
    check("mid_alu_A", 32'(alu_A), 32'd0);
    tick();
    check("mid_stay_rv", 32'(bus.rsp_valid), 32'd0);
    do_op("post_rst", 2'b01, 4'd9, 4'd4, 5'd5, 3'b100);

    // ops_done wrap
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
    end
    check("wrap_255", 32'(ops_done), 32'd255);
    exp_ops = 255;
    do_op("wrap_0", 2'b11, 4'd6, 4'd3, 5'd2, 3'b100);

`ifdef ALU_SEQ_SCOREBOARD_EN
    do_reset();
    check("sb_rst_sticky", 32'(err_sticky), 32'd0);
    check("sb_rst_cnt", 32'(err_count), 32'd0);
    inject_fault  = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 4'd12;
    bus.req_b     = 4'd3;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("sb_issue_sticky", 32'(err_sticky), 32'd0);
    tick();
    check("sb_rv", 32'(bus.rsp_valid), 32'd1);
    check("sb_y", 32'(bus.rsp_y), 32'd0);
    check("sb_sticky", 32'(err_sticky), 32'd1);
    check("sb_cnt", 32'(err_count), 32'd1);
    tick();
    inject_fault = 1'b0;
    exp_ops = 1;
    do_op("sb_good", 2'b00, 4'd2, 4'd3, 5'd5, 3'b001);
    check("sb_keep_sticky", 32'(err_sticky), 32'd1);
    check("sb_keep_cnt", 32'(err_count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
